// File: rtl/bit_serial_alu.sv
// bit_serial_alu: LSB-first bit-serial execute unit around a single ALU bit slice.
// Produces a WIDTH-bit result plus N/Z/V/C flags WIDTH cycles after start is accepted.
`default_nettype none

module bit_serial_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       cntrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [2:0]       op;
  logic [CW-1:0]    cnt;
  logic             cy;

  logic             b_eff;
  logic             sum;
  logic             cout;
  logic             slice_bit;
  logic             is_arith;
  logic             is_rsvd;
  logic             last;
  logic [WIDTH-1:0] res_next;

  // Single bit slice; subtract inverts b ahead of the adder only.
  always_comb begin
    b_eff = b_sr[0] ^ (op == 3'b011);
    sum   = a_sr[0] ^ b_eff ^ cy;
    cout  = (a_sr[0] & b_eff) | (cy & (a_sr[0] ^ b_eff));
    case (op)
      3'b000:         slice_bit = b_sr[0];
      3'b010, 3'b011: slice_bit = sum;
      3'b100:         slice_bit = a_sr[0] & b_sr[0];
      3'b101:         slice_bit = a_sr[0] | b_sr[0];
      3'b110:         slice_bit = a_sr[0] ^ b_sr[0];
      default:        slice_bit = 1'b0;
    endcase
  end

  assign is_arith = (op == 3'b010) || (op == 3'b011);
  assign is_rsvd  = (op == 3'b001) || (op == 3'b111);
  assign last     = (cnt == LAST);
  assign res_next = {slice_bit, res_sr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      op        <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            op   <= cntrl;
            cnt  <= '0;
            cy   <= (cntrl == 3'b011);
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_next[WIDTH-1:1];
          if (is_arith) begin
            cy <= cout;
          end
          if (last) begin
            // Reserved codes run the full sequence but leave the visible result untouched.
            if (!is_rsvd) begin
              result    <= res_next;
              negative  <= slice_bit;
              zero      <= (res_next == '0);
              carry_out <= is_arith & cout;
              overflow  <= is_arith & (cy ^ cout);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: self-checking bench for bit_serial_alu at WIDTH=8 and WIDTH=64,
// comparing against an arithmetic reference model of the operation set.
`default_nettype none

module tb_bit_serial_alu;

  logic        clk;
  logic        reset;

  logic        start8, start64;
  logic [2:0]  op8, op64;
  logic [7:0]  a8, b8;
  logic [63:0] a64, b64;

  logic        busy8, done8, n8, z8, v8, c8;
  logic [7:0]  res8;
  logic        busy64, done64, n64, z64, v64, c64;
  logic [63:0] res64;

  bit          cur;
  logic [63:0] o_res;
  logic [3:0]  o_fl;
  logic        o_busy, o_done;

  int          total;
  int          bad;
  logic [67:0] exp8, exp64;

  bit_serial_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .cntrl(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .result(res8), .negative(n8), .zero(z8),
    .overflow(v8), .carry_out(c8)
  );

  bit_serial_alu #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .cntrl(op64), .A(a64), .B(b64),
    .busy(busy64), .done(done64), .result(res64), .negative(n64), .zero(z64),
    .overflow(v64), .carry_out(c64)
  );

  assign o_res  = cur ? res64 : {56'd0, res8};
  assign o_fl   = cur ? {n64, z64, v64, c64} : {n8, z8, v8, c8};
  assign o_busy = cur ? busy64 : busy8;
  assign o_done = cur ? done64 : done8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {result[63:0], N, Z, V, C}; reserved codes return the previous state.
  function automatic logic [67:0] ref_op(input int w, input logic [2:0] op,
                                          input logic [63:0] a_in, input logic [63:0] b_in,
                                          input logic [67:0] prev);
    logic [64:0] full;
    logic [63:0] mask, a, b, r;
    logic        v, c;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    v = 1'b0;
    c = 1'b0;
    r = '0;
    full = '0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        full = {1'b0, a} + {1'b0, b};
        r = full[63:0] & mask;
        c = full[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'b011: begin
        full = {1'b0, a} + {1'b0, (~b) & mask} + 65'd1;
        r = full[63:0] & mask;
        c = full[w];
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: return prev;
    endcase
    return {r, r[w-1], (r == 64'd0), v, c};
  endfunction

  task automatic drive(input bit sel, input logic s, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    cur = sel;
    if (sel) begin
      start64 = s; op64 = op; a64 = a; b64 = b;
    end else begin
      start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // One full operation; inputs are scrambled after the accepting edge.
  task automatic run_op(input bit sel, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, output int lat, output logic [63:0] res,
                        output logic [3:0] fl, output logic [1:0] tail);
    int w;
    w = sel ? 64 : 8;
    @(negedge clk);
    drive(sel, 1'b1, op, a, b);
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= w + 4; i++) begin
      @(negedge clk);
      drive(sel, 1'b0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clk); #1;
      if (o_done) begin
        lat = i;
        break;
      end
    end
    res = o_res;
    fl  = o_fl;
    @(posedge clk); #1;
    tail = {o_busy, o_done};
  endtask

  task automatic test_reset();
    logic [13:0] s8;
    logic [69:0] s64;
    int lat;
    logic [63:0] r;
    logic [3:0] f;
    logic [1:0] t;
    logic [67:0] e;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s8 = {busy8, done8, res8, n8, z8, v8, c8};
    s64 = {busy64, done64, res64, n64, z64, v64, c64};
    total++; if (s8 !== '0) begin bad++; $display("FAIL por_w8 got=%h want=0", s8); end
    total++; if (s64 !== '0) begin bad++; $display("FAIL por_w64 got=%h want=0", s64); end
    @(negedge clk); reset = 1'b1;
    // Load non-zero results, then abort a second ADD mid-RUN.
    run_op(1'b0, 3'b010, 64'h7F, 64'h01, lat, r, f, t);
    run_op(1'b1, 3'b011, 64'd0, 64'd1, lat, r, f, t);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 64'h11, 64'h22);
    drive(1'b1, 1'b1, 3'b010, 64'h11, 64'h22);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 3'b000, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    s8 = {busy8, done8, res8, n8, z8, v8, c8};
    s64 = {busy64, done64, res64, n64, z64, v64, c64};
    total++; if (s8 !== '0) begin bad++; $display("FAIL abort_w8 got=%h want=0", s8); end
    total++; if (s64 !== '0) begin bad++; $display("FAIL abort_w64 got=%h want=0", s64); end
    @(negedge clk); reset = 1'b1;
    exp8 = '0;
    exp64 = '0;
    run_op(1'b0, 3'b010, 64'h12, 64'h34, lat, r, f, t);
    e = ref_op(8, 3'b010, 64'h12, 64'h34, exp8);
    exp8 = e;
    total++;
    if (r !== e[67:4] || f !== e[3:0] || lat != 8) begin
      bad++; $display("FAIL post_reset_op got=%h/%b lat=%0d want=%h/%b lat=8", r, f, lat, e[67:4], e[3:0]);
    end
  endtask

  task automatic test_directed();
    bit          vs[7];
    logic [2:0]  vo[7];
    logic [63:0] va[7], vb[7], vr[7];
    logic [3:0]  vf[7];
    int lat;
    logic [63:0] r;
    logic [3:0] f;
    logic [1:0] t;
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vo = '{3'b010, 3'b011, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000};
    va = '{64'h7F, 64'h05, 64'h00, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0,
           64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0};
    vb = '{64'h01, 64'h05, 64'h01, 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00,
           64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00};
    vr = '{64'h80, 64'h00, 64'hFF, 64'hF000_F000_F000_F000, 64'hFFF0_FFF0_FFF0_FFF0,
           64'h0FF0_0FF0_0FF0_0FF0, 64'hFF00_FF00_FF00_FF00};
    vf = '{4'b1010, 4'b0101, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    for (int k = 0; k < 7; k++) begin
      run_op(vs[k], vo[k], va[k], vb[k], lat, r, f, t);
      if (vs[k]) exp64 = ref_op(64, vo[k], va[k], vb[k], exp64);
      else       exp8  = ref_op(8, vo[k], va[k], vb[k], exp8);
      total++;
      if (r !== vr[k] || f !== vf[k]) begin
        bad++; $display("FAIL directed%0d got=%h nzvc=%b want=%h nzvc=%b", k, r, f, vr[k], vf[k]);
      end
      total++;
      if (lat != (vs[k] ? 64 : 8) || t !== 2'b00) begin
        bad++; $display("FAIL directed%0d_timing lat=%0d tail=%b want lat=%0d tail=00", k, lat, t, vs[k] ? 64 : 8);
      end
    end
  endtask

  task automatic test_reserved();
    int lat;
    logic [63:0] r;
    logic [3:0] f;
    logic [1:0] t;
    run_op(1'b0, 3'b010, 64'h7F, 64'h01, lat, r, f, t);
    exp8 = ref_op(8, 3'b010, 64'h7F, 64'h01, exp8);
    run_op(1'b0, 3'b001, 64'h0F, 64'h0F, lat, r, f, t);
    total++;
    if (r !== 64'h80 || f !== 4'b1010 || lat != 8) begin
      bad++; $display("FAIL reserved001 got=%h nzvc=%b lat=%0d want=80 nzvc=1010 lat=8", r, f, lat);
    end
    run_op(1'b0, 3'b111, 64'hFF, 64'h00, lat, r, f, t);
    total++;
    if (r !== 64'h80 || f !== 4'b1010 || lat != 8) begin
      bad++; $display("FAIL reserved111 got=%h nzvc=%b lat=%0d want=80 nzvc=1010 lat=8", r, f, lat);
    end
  endtask

  task automatic test_random();
    bit sel;
    logic [2:0] op;
    logic [63:0] a, b, r;
    logic [3:0] f;
    logic [1:0] t;
    logic [67:0] e;
    int lat, w;
    for (int k = 0; k < 24; k++) begin
      sel = 1'($urandom);
      op  = 3'($urandom);
      a   = {$urandom, $urandom};
      b   = (k % 5 == 0) ? a : {$urandom, $urandom};
      w   = sel ? 64 : 8;
      run_op(sel, op, a, b, lat, r, f, t);
      e = ref_op(w, op, a, b, sel ? exp64 : exp8);
      if (sel) exp64 = e; else exp8 = e;
      total++;
      if (r !== e[67:4] || f !== e[3:0]) begin
        bad++; $display("FAIL random%0d w=%0d op=%b got=%h nzvc=%b want=%h nzvc=%b", k, w, op, r, f, e[67:4], e[3:0]);
      end
      total++;
      if (lat != w || t !== 2'b00) begin
        bad++; $display("FAIL random%0d_timing lat=%0d tail=%b want lat=%0d tail=00", k, lat, t, w);
      end
    end
  endtask

  task automatic test_back_to_back();
    int p;
    logic [7:0] av[30], bv[30];
    logic [67:0] e;
    p = 10;
    e = exp8;
    for (int t = 0; t < 3 * p; t++) begin
      @(negedge clk);
      av[t] = 8'($urandom);
      bv[t] = 8'($urandom);
      drive(1'b0, 1'b1, 3'b010, {56'd0, av[t]}, {56'd0, bv[t]});
      @(posedge clk); #1;
      total++;
      if (o_done !== 1'(t % p == 8)) begin
        bad++; $display("FAIL b2b_done edge=%0d got=%b want=%b", t, o_done, (t % p == 8));
      end
      total++;
      if (o_busy !== 1'(t % p != 9)) begin
        bad++; $display("FAIL b2b_busy edge=%0d got=%b want=%b", t, o_busy, (t % p != 9));
      end
      if (t % p == 8) begin
        e = ref_op(8, 3'b010, {56'd0, av[t-8]}, {56'd0, bv[t-8]}, e);
        total++;
        if (o_res !== e[67:4] || o_fl !== e[3:0]) begin
          bad++; $display("FAIL b2b_result edge=%0d got=%h nzvc=%b want=%h nzvc=%b", t, o_res, o_fl, e[67:4], e[3:0]);
        end
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
    exp8 = e;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp8  = '0;
    exp64 = '0;
    cur   = 1'b0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    start64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_reserved();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bit_serial_alu.md
# bit_serial_alu

Bit-serial execute unit that feeds a single ALU bit slice one bit per clock, LSB first, and reassembles a WIDTH-bit result with N/Z/V/C flags. It sits directly upstream of the bit-slice logic and wraps it with operand shift registers, a carry flop, a bit counter and a start/done handshake. It is an area-minimal alternative to the ripple ALU for multi-cycle operations in the datapath.

## Interface
- WIDTH, 64, operand/result width in bits (≥ 2).

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately).
- start  input  1  request; sampled only in IDLE.
- cntrl  input  3  operation code, bit-slice encoding: 000 pass B, 010 A+B, 011 A−B, 100 AND, 101 OR, 110 XOR; 001/111 reserved.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  last completed result, held until the next completion.
- negative  output  1  result[WIDTH-1].
- zero  output  1  result == 0.
- overflow  output  1  signed overflow, add/sub only; else 0.
- carry_out  output  1  carry out of MSB, add/sub only; else 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch A, B and cntrl into internal registers; bit counter = 0; carry flop = 1 if cntrl==011, else 0; go to RUN.
- RUN, each cycle, bit i = counter:
  - Slice inputs: a = A_reg[0], b = B_reg[0], cin = carry flop.
  - For subtract, b is inverted before the adder. AND/OR/XOR/pass use the uninverted b.
  - Slice output bit enters the result shift register at the MSB; the register shifts right.
  - A_reg and B_reg shift right by 1.
  - The carry flop loads the slice carry only for 010/011. For other codes it holds.
  - When i == WIDTH-1:
    - capture carry-in of the MSB for the overflow calculation;
    - go to DONE;
    - load result, negative and zero from the shift register including this final bit;
    - for add/sub: carry_out = MSB carry out, overflow = MSB carry-in XOR MSB carry-out; for other codes both are 0.
  - Otherwise increment the counter.
- Reserved codes (001, 111): sequence runs its full WIDTH cycles, but result and all four flags keep their previous values; done still pulses.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored; no queuing. A, B and cntrl changes after the start edge have no effect.
- Arithmetic is modulo 2^WIDTH. Subtract is A + ~B + 1, so carry_out = 1 means no borrow.

## Timing
- Edge E0 samples start=1 in IDLE; busy rises after E0.
- Edges E1..E_WIDTH process bits 0..WIDTH-1.
- At E_WIDTH: result and flags update and done rises; busy stays high.
- At E_WIDTH+1: done and busy fall and state returns to IDLE.
- Earliest next start is sampled at E_WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Latency from start edge to done is WIDTH cycles.
- Reset value of every output and register is 0: busy, done, result, negative, zero, overflow, carry_out, counter, carry flop. State resets to IDLE.
  - Note: zero output resets to 0, not 1; it is only updated at completion.
- Reset mid-RUN or mid-DONE aborts immediately: no done pulse, result and flags cleared.
- Counter wrap: the counter never exceeds WIDTH-1; the transition to DONE happens at that value.

## Test plan
- Reset: start an ADD, drive reset=0 at cycle 3 of RUN → all outputs 0 asynchronously, state IDLE. After release, start=1 runs a fresh operation normally.
- WIDTH=8, ADD 0x7F+0x01 → done exactly 8 cycles after the start edge; result 0x80, negative=1, overflow=1, carry_out=0, zero=0.
- WIDTH=8, SUB 0x05−0x05 → result 0x00, zero=1, carry_out=1, overflow=0. SUB 0x00−0x01 → result 0xFF, negative=1, carry_out=0, overflow=0.
- WIDTH=64, A=0xF0F0_F0F0_F0F0_F0F0, B=0xFF00_FF00_FF00_FF00:
  - AND → 0xF000_F000_F000_F000;
  - OR → 0xFFF0_FFF0_FFF0_FFF0;
  - XOR → 0x0FF0_0FF0_0FF0_0FF0;
  - pass → B;
  - overflow = carry_out = 0 for each.
- Handshake: hold start=1 continuously with A/B toggling every cycle → operands captured only at accepting edges; one done pulse per WIDTH+2 cycles; busy never drops between back-to-back operations except the single IDLE cycle.
- Reserved code: after ADD giving 0x80 (WIDTH=8), issue cntrl=001 → done pulses after 8 cycles; result stays 0x80 and flags are unchanged.
